// File: rtl/olink_tx_framer_if.sv
// Payload handshake between the word source and the optical-link transmit framer.
// The source drives in_d/in_v and the framer answers with in_rdy.
interface olink_tx_framer_if;
    logic [31:0] in_d;
    logic        in_v;
    logic        in_rdy;

    modport master (output in_d, in_v, input in_rdy);
    modport slave  (input in_d, in_v, output in_rdy);
endinterface

// File: rtl/olink_tx_framer.sv
// Transmit framer: turns 32-bit payload words into LO/HI 16-bit halves for the GTX.
// Also inserts sequence-numbered comma pairs and fills unused pairs with IDLE.
module olink_tx_framer #(
    parameter int unsigned COMMA_PERIOD = 64
) (
    input  logic                   clk_link,
    input  logic                   reset_n,
    input  logic                   enable,
    olink_tx_framer_if.slave       in_bus,
    input  logic [15:0]            comma_user,
    input  logic                   comma_req,
    input  logic                   counter_reset,
    output logic [15:0]            tx_d,
    output logic [1:0]             tx_k,
    output logic [31:0]            words_sent,
    output logic [15:0]            commas_sent
);
    typedef enum logic [1:0] {
        PAIR_IDLE,
        PAIR_DATA,
        PAIR_COMMA
    } pair_t;

    localparam logic [15:0] IDLE_WORD = 16'hF7F7;
    localparam logic [15:0] CNT_LAST  = 16'(COMMA_PERIOD - 1);

    logic        phase_hi;
    pair_t       pair;
    logic [15:0] hold;
    logic [15:0] pair_cnt;
    logic [7:0]  seq;
    logic        first_flag;
    logic        comma_pending;
    logic        comma_sel;
    logic        xfer;
    logic        comma_inc;

    // Comma selection depends only on registered state, so in_rdy never looks at in_v.
    assign comma_sel     = first_flag || comma_pending || (pair_cnt == CNT_LAST);
    assign in_bus.in_rdy = phase_hi && enable && !comma_sel;
    assign xfer          = in_bus.in_v && in_bus.in_rdy;
    assign comma_inc     = phase_hi && comma_sel;

    always_ff @(posedge clk_link or negedge reset_n) begin
        if (!reset_n) begin
            phase_hi      <= 1'b1;
            pair          <= PAIR_IDLE;
            hold          <= IDLE_WORD;
            pair_cnt      <= '0;
            seq           <= '0;
            first_flag    <= 1'b1;
            comma_pending <= 1'b0;
            tx_d          <= IDLE_WORD;
            tx_k          <= '1;
            words_sent    <= '0;
            commas_sent   <= '0;
        end else begin
            phase_hi <= !phase_hi;
            if (phase_hi) begin
                first_flag <= 1'b0;
                if (comma_sel) begin
                    pair     <= PAIR_COMMA;
                    tx_d     <= {seq, 8'hBC};
                    tx_k     <= 2'b01;
                    hold     <= comma_user;
                    seq      <= seq + 8'd1;
                    pair_cnt <= '0;
                end else begin
                    pair_cnt <= pair_cnt + 16'd1;
                    if (xfer) begin
                        pair <= PAIR_DATA;
                        tx_d <= in_bus.in_d[15:0];
                        tx_k <= '0;
                        hold <= in_bus.in_d[31:16];
                    end else begin
                        pair <= PAIR_IDLE;
                        tx_d <= IDLE_WORD;
                        tx_k <= '1;
                        hold <= IDLE_WORD;
                    end
                end
            end else begin
                tx_d <= hold;
                tx_k <= (pair == PAIR_IDLE) ? 2'b11 : 2'b00;
            end

            // A request that lands on a comma selection is satisfied by that comma.
            if (comma_inc) begin
                comma_pending <= 1'b0;
            end else if (comma_req) begin
                comma_pending <= 1'b1;
            end

            if (counter_reset) begin
                words_sent <= '0;
            end else if (xfer) begin
                words_sent <= words_sent + 32'd1;
            end

            if (counter_reset) begin
                commas_sent <= '0;
            end else if (comma_inc) begin
                commas_sent <= commas_sent + 16'd1;
            end
        end
    end
endmodule
